mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Main control unit of the multicycle MIPS datapath. A Moore state machine sequences every instruction through fetch, decode, execute, memory and writeback. It drives the datapath's mux selects and write enables, including `regWrite` and the `regDst`/`memtoReg` selects that form the register file's write port. A small combinational ALU decoder maps `aluOp` and `funct` to the ALU operation code.

## Interface
Parameters: none.

- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `opcode`  in  6  instr[31:26] from instruction register; valid from DECODE onward
- `funct`  in  6  instr[5:0] from instruction register
- `zero`  in  1  ALU zero flag, sampled combinationally in BRANCH
- `pcEn`  out  1  PC load enable = pcWrite | (branch & zero) | (bne & ~zero)
- `iorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `memWrite`  out  1  data memory write strobe
- `irWrite`  out  1  instruction register load
- `regWrite`  out  1  register file write enable
- `regDst`  out  1  write register select: 0 = rt, 1 = rd
- `memtoReg`  out  1  write data select: 0 = ALUOut, 1 = MDR
- `aluSrcA`  out  1  0 = PC, 1 = A
- `aluSrcB`  out  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- `pcSrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `aluControl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- `state_o`  out  4  current state encoding, for debug and coverage

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010, BNE 000101 (macro-gated).
- FETCH: irWrite=1, pcWrite=1, aluSrcB=01, aluOp=00. Next state is DECODE.
- DECODE: aluSrcB=11, aluOp=00 (branch target into ALUOut). Next state by opcode:
  - LW/SW → MEMADR
  - R → EXECUTE
  - BEQ/BNE → BRANCH
  - ADDI → ADDIEXEC
  - J → JUMP
  - any other opcode → FETCH, with no side effects.
- MEMADR: aluSrcA=1, aluSrcB=10. LW → MEMREAD; SW → MEMWRITE.
- MEMREAD: iorD=1. Next state is MEMWB.
- MEMWB: regWrite=1, memtoReg=1, regDst=0. Next state is FETCH.
- MEMWRITE: iorD=1, memWrite=1. Next state is FETCH.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10. Next state is ALUWB.
- ALUWB: regWrite=1, regDst=1, memtoReg=0. Next state is FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01. Asserts branch (BEQ) or bne (BNE). Next state is FETCH.
- ADDIEXEC: aluSrcA=1, aluSrcB=10, aluOp=00. Next state is ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memtoReg=0. Next state is FETCH.
- JUMP: pcSrc=10, pcWrite=1. Next state is FETCH.
- Signals not listed for a state are 0.
- ALU decode:
  - aluOp 00 → 010; aluOp 01 → 110.
  - aluOp 10 with funct 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111; any other funct → 010.
  - aluOp 11 is unused and decodes to 010.

## Timing
- While `rst`=1: state forced to FETCH and every output is 0, including `pcEn`, `irWrite` and `regWrite`. `state_o` = FETCH encoding.
- First FETCH actions occur in the first cycle after `rst` deasserts.
- Reset asserted mid-instruction aborts it immediately. No write strobe survives the reset edge.
- Exactly one state transition per rising edge. Outputs are Moore: a pure function of state, plus `zero` for `pcEn`, plus `funct` for `aluControl`.
- Instruction latency in cycles: R 4, LW 5, SW 4, BEQ/BNE 3, ADDI 4, J 3, illegal 2.
- `regWrite` and `memWrite` are each high for exactly one cycle per instruction that writes.

## Configuration
- `MIPS_CTRL_BNE_EN` defined:
  - opcode 000101 goes DECODE → BRANCH.
  - In BRANCH, `pcEn` = `~zero` for BNE and `zero` for BEQ.
- Undefined:
  - 000101 is illegal and goes DECODE → FETCH.
  - The bne term is tied to 0.

## Structure
- Package `mips_ctrl_pkg`:
  - `state_t` enum (4 bits: FETCH=0 … JUMP=11)
  - opcode localparams
  - aluOp and aluControl constants
- Sub-module `mips_alu_decoder`: combinational (aluOp, funct) → aluControl, instantiated once.

## Test plan
- Reset held for 3 cycles mid-LW (state MEMREAD) → all outputs 0 during reset; FETCH with irWrite=1, pcEn=1 on the first cycle after release.
- R-type add (funct 100000): states FETCH, DECODE, EXECUTE, ALUWB → aluControl=010 in EXECUTE; regWrite=1, regDst=1 in cycle 4 only.
- LW then SW → 5 and 4 cycles. regWrite=1, memtoReg=1 in MEMWB; memWrite=1, iorD=1 in MEMWRITE; regWrite=0 throughout SW.
- BEQ with zero=1, then BEQ with zero=0 → pcEn=1 vs pcEn=0 in BRANCH, with aluControl=110 and pcSrc=01.
- BNE (000101) with zero=0:
  - with macro: BRANCH, pcEn=1
  - without macro: DECODE → FETCH with no strobes.
- Illegal opcode 111111, then J → 2-cycle return to FETCH; JUMP asserts pcSrc=10, pcEn=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encoding, opcodes and ALU codes for the multicycle MIPS controller.
package mips_ctrl_pkg;
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps (aluOp, funct) to the ALU operation code; unknown functs and aluOp 11 fall back to add.
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_control_o
);
   logic [2:0] fn_ctrl;
   always_comb begin
      fn_ctrl = funct_i == FN_SUB ? ALU_SUB :
                funct_i == FN_AND ? ALU_AND :
                funct_i == FN_OR  ? ALU_OR  :
                funct_i == FN_SLT ? ALU_SLT : ALU_ADD;
      alu_control_o = alu_op_i == ALUOP_SUB   ? ALU_SUB :
                      alu_op_i == ALUOP_FUNCT ? fn_ctrl : ALU_ADD;
   end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM of the multicycle MIPS datapath.
// Define MIPS_CTRL_BNE_EN to decode opcode 000101 as BNE; otherwise it is illegal.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcEn,
   output logic       iorD,
   output logic       memWrite,
   output logic       irWrite,
   output logic       regWrite,
   output logic       regDst,
   output logic       memtoReg,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] pcSrc,
   output logic [2:0] aluControl,
   output logic [3:0] state_o
);
   state_t     state_q, state_d;
   logic       pc_write, branch, bne, bne_op;
   logic [1:0] alu_op;
   logic [2:0] alu_ctrl;
`ifdef MIPS_CTRL_BNE_EN
   assign bne_op = opcode == OP_BNE;
`else
   assign bne_op = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   // Outputs are held low while rst is asserted, even though the state already reads FETCH.
   always_comb begin
      state_d  = FETCH;
      pc_write = 1'b0;
      branch   = 1'b0;
      bne      = 1'b0;
      iorD     = 1'b0;
      memWrite = 1'b0;
      irWrite  = 1'b0;
      regWrite = 1'b0;
      regDst   = 1'b0;
      memtoReg = 1'b0;
      aluSrcA  = 1'b0;
      aluSrcB  = 2'b00;
      pcSrc    = 2'b00;
      alu_op   = ALUOP_ADD;
      if (!rst)
         case (state_q)
            FETCH: begin
               irWrite  = 1'b1;
               pc_write = 1'b1;
               aluSrcB  = 2'b01;
               state_d  = DECODE;
            end
            DECODE: begin
               aluSrcB = 2'b11;
               state_d = (opcode == OP_LW || opcode == OP_SW) ? MEMADR   :
                         opcode == OP_R                       ? EXECUTE  :
                         (opcode == OP_BEQ || bne_op)         ? BRANCH   :
                         opcode == OP_ADDI                    ? ADDIEXEC :
                         opcode == OP_J                       ? JUMP     : FETCH;
            end
            MEMADR: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
               state_d = opcode == OP_LW ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
               iorD    = 1'b1;
               state_d = MEMWB;
            end
            MEMWB: begin
               regWrite = 1'b1;
               memtoReg = 1'b1;
            end
            MEMWRITE: begin
               iorD     = 1'b1;
               memWrite = 1'b1;
            end
            EXECUTE: begin
               aluSrcA = 1'b1;
               alu_op  = ALUOP_FUNCT;
               state_d = ALUWB;
            end
            ALUWB: begin
               regWrite = 1'b1;
               regDst   = 1'b1;
            end
            BRANCH: begin
               aluSrcA = 1'b1;
               alu_op  = ALUOP_SUB;
               pcSrc   = 2'b01;
               branch  = opcode == OP_BEQ;
               bne     = bne_op;
            end
            ADDIEXEC: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
               state_d = ADDIWB;
            end
            ADDIWB: regWrite = 1'b1;
            JUMP: begin
               pcSrc    = 2'b10;
               pc_write = 1'b1;
            end
            default: state_d = FETCH;
         endcase
   end
   mips_alu_decoder u_alu_dec (
      .alu_op_i      (alu_op),
      .funct_i       (funct),
      .alu_control_o (alu_ctrl)
   );
   assign pcEn       = pc_write | (branch & zero) | (bne & ~zero);
   assign aluControl = rst ? 3'b000 : alu_ctrl;
   assign state_o    = state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: vector table, reset corner case and random instruction stream against a per-instruction step model.
module tb_mips_multicycle_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic       zero;
   logic       pcEn, iorD, memWrite, irWrite, regWrite, regDst, memtoReg, aluSrcA;
   logic [1:0] aluSrcB, pcSrc;
   logic [2:0] aluControl;
   logic [3:0] state_o;
   int passed = 0;
   int total  = 0;
   logic [18:0] exp_q[$];
`ifdef MIPS_CTRL_BNE_EN
   localparam bit BNE_EN = 1'b1;
`else
   localparam bit BNE_EN = 1'b0;
`endif
   mips_multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .pcEn(pcEn), .iorD(iorD), .memWrite(memWrite), .irWrite(irWrite),
      .regWrite(regWrite), .regDst(regDst), .memtoReg(memtoReg), .aluSrcA(aluSrcA),
      .aluSrcB(aluSrcB), .pcSrc(pcSrc), .aluControl(aluControl), .state_o(state_o)
   );
   always #5 clk = ~clk;
   wire [18:0] act = {state_o, pcEn, iorD, memWrite, irWrite, regWrite, regDst,
                      memtoReg, aluSrcA, aluSrcB, pcSrc, aluControl};
   function automatic logic [18:0] pk(input logic [3:0] st, input logic pe, io, mw, iw, rw, rd, m2r, sa,
                                      input logic [1:0] sb, ps, input logic [2:0] ac);
      return {st, pe, io, mw, iw, rw, rd, m2r, sa, sb, ps, ac};
   endfunction
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, want);
   endtask
   function automatic logic [2:0] alu_ref(input logic [5:0] fn);
      case (fn)
         6'h20:   return 3'b010;
         6'h22:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         6'h2a:   return 3'b111;
         default: return 3'b010;
      endcase
   endfunction
   // Expected per-cycle outputs for one instruction, from the instruction's step list.
   function automatic void model(input logic [5:0] op, input logic [5:0] fn, input logic z);
      exp_q.delete();
      exp_q.push_back(pk(4'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010));
      exp_q.push_back(pk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010));
      if (op == 6'b100011 || op == 6'b101011)
         exp_q.push_back(pk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010));
      if (op == 6'b100011) begin
         exp_q.push_back(pk(4'd3, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010));
         exp_q.push_back(pk(4'd4, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010));
      end
      if (op == 6'b101011)
         exp_q.push_back(pk(4'd5, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010));
      if (op == 6'b000000) begin
         exp_q.push_back(pk(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, alu_ref(fn)));
         exp_q.push_back(pk(4'd7, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b010));
      end
      if (op == 6'b000100)
         exp_q.push_back(pk(4'd8, z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110));
      if (op == 6'b000101 && BNE_EN)
         exp_q.push_back(pk(4'd8, ~z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110));
      if (op == 6'b001000) begin
         exp_q.push_back(pk(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010));
         exp_q.push_back(pk(4'd10, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010));
      end
      if (op == 6'b000010)
         exp_q.push_back(pk(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010));
   endfunction
   // Entered on a falling edge with the DUT in FETCH; leaves on the falling edge of the next FETCH.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            output int lat, output int nrw, output int nmw);
      opcode = op;
      funct  = fn;
      zero   = z;
      model(op, fn, z);
      lat = 0; nrw = 0; nmw = 0;
      do begin
         #1;
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL seq_overrun op=%b: got state %0d with no expected cycle left", op, state_o);
         end else check($sformatf("op%b_fn%h_z%0d_cyc%0d", op, fn, z, lat), act, exp_q.pop_front());
         nrw += regWrite;
         nmw += memWrite;
         lat++;
         @(negedge clk);
      end while (state_o != 4'd0 && lat < 10);
      check($sformatf("seq_len_op%b", op), exp_q.size(), 0);
   endtask
   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         lat;
      int         nrw;
      int         nmw;
   } vec_t;
   vec_t tbl[11];
   initial begin
      int lat, nrw, nmw;
      logic [5:0] ops[8];
      logic [5:0] fns[6];
      tbl[0]  = '{6'b000000, 6'b100000, 1'b0, 4, 1, 0};
      tbl[1]  = '{6'b000000, 6'b100010, 1'b1, 4, 1, 0};
      tbl[2]  = '{6'b100011, 6'b000000, 1'b0, 5, 1, 0};
      tbl[3]  = '{6'b101011, 6'b000000, 1'b0, 4, 0, 1};
      tbl[4]  = '{6'b000100, 6'b000000, 1'b1, 3, 0, 0};
      tbl[5]  = '{6'b000100, 6'b000000, 1'b0, 3, 0, 0};
      tbl[6]  = '{6'b001000, 6'b000000, 1'b0, 4, 1, 0};
      tbl[7]  = '{6'b000010, 6'b000000, 1'b0, 3, 0, 0};
      tbl[8]  = '{6'b111111, 6'b000000, 1'b0, 2, 0, 0};
      tbl[9]  = '{6'b000101, 6'b000000, 1'b0, BNE_EN ? 3 : 2, 0, 0};
      tbl[10] = '{6'b000000, 6'b101010, 1'b0, 4, 1, 0};
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000101, 6'b110011};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};
      rst = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0;
      repeat (2) @(negedge clk);
      #1 check("reset_outputs", act, 0);
      @(negedge clk);
      rst = 1'b0;
      foreach (tbl[i]) begin
         run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, lat, nrw, nmw);
         check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
         check($sformatf("tbl%0d_regwrite_cycles", i), nrw, tbl[i].nrw);
         check($sformatf("tbl%0d_memwrite_cycles", i), nmw, tbl[i].nmw);
      end
      // Abort an LW in MEMREAD with a 3-cycle reset.
      opcode = 6'b100011;
      repeat (3) @(negedge clk);
      check("lw_reaches_memread", state_o, 4'd3);
      rst = 1'b1;
      #1 check("reset_async_outputs", act, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1 check($sformatf("reset_hold_%0d", c), act, 0);
      end
      rst = 1'b0;
      #1 check("first_fetch_after_reset", act, pk(4'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010));
      for (int n = 0; n < 300; n++) begin
         logic [5:0] op, fn;
         op = ops[$urandom_range(0, 7)];
         if (op == 6'b110011) op = 6'($urandom);
         fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
         run_instr(op, fn, 1'($urandom), lat, nrw, nmw);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
